fifo_wr_arbiter: RTL



---
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async_fifo write port among NREQ requesters.
// The grant is held until the burst's last beat or MAXBURST beats, and handover to the next requester has no bubble.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 2,
    parameter int MAXBURST = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_valid,
    input  logic [NREQ*DSIZE-1:0]  i_data,
    input  logic [NREQ-1:0]        i_last,
    output logic [NREQ-1:0]        o_ready,
    output logic                   o_fifo_wr,
    output logic [DSIZE-1:0]       o_fifo_wdata,
    input  logic                   i_fifo_full,
    output logic [NREQ-1:0]        o_grant,
    output logic                   o_busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg;
    logic [IW-1:0]   gnt_idx_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic [NREQ-1:0] grant_reg;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic [NREQ-1:0]  cand_vec;
    logic [IW-1:0]    search_base;
    logic [IW-1:0]    cand_idx;
    logic [IW-1:0]    pick_idx;
    logic             pick_found;
    logic             beat;
    logic             burst_end;
    logic             release_now;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign data_arr[gi] = i_data[gi*DSIZE +: DSIZE];
            assign o_ready[gi]  = beat && (gnt_idx_reg == IW'(gi));
        end
    endgenerate

    assign beat         = (state_reg == BUSY) && i_valid[gnt_idx_reg] && !i_fifo_full;
    assign burst_end    = i_last[gnt_idx_reg] || (beat_cnt_reg == CW'(MAXBURST - 1));
    assign release_now  = beat && burst_end;
    assign o_fifo_wr    = beat;
    assign o_fifo_wdata = (state_reg == BUSY) ? data_arr[gnt_idx_reg] : '0;
    assign o_grant      = grant_reg;
    assign o_busy       = (state_reg == BUSY);

    // While BUSY the pick is only used on a release edge, so the releasing requester is masked out
    // and the search starts just past it.
    always_comb begin
        search_base = (state_reg == BUSY) ? gnt_idx_reg : rr_ptr_reg;
        cand_vec    = i_valid;
        if (state_reg == BUSY) begin
            cand_vec[gnt_idx_reg] = 1'b0;
        end
        cand_idx   = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IW'((int'(search_base) + k) % NREQ);
            if (!pick_found && cand_vec[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            gnt_idx_reg  <= '0;
            rr_ptr_reg   <= IW'(NREQ - 1);
            beat_cnt_reg <= '0;
            grant_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg    <= BUSY;
                        gnt_idx_reg  <= pick_idx;
                        grant_reg    <= NREQ'(1) << pick_idx;
                        beat_cnt_reg <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        rr_ptr_reg   <= gnt_idx_reg;
                        beat_cnt_reg <= '0;
                        if (pick_found) begin
                            gnt_idx_reg <= pick_idx;
                            grant_reg   <= NREQ'(1) << pick_idx;
                        end else begin
                            state_reg <= IDLE;
                            grant_reg <= '0;
                        end
                    end else if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
